// File: rtl/mac_pkg.sv
// Shared types and geometry helpers for the multi-precision MAC processing element.
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_X1 = 2'b00,
    MODE_X2 = 2'b01,
    MODE_X4 = 2'b10
  } mode_e;

  localparam int NUM_GEOM  = 3;
  localparam int MAX_LANES = 4;

  function automatic int lanes_of(input mode_e m);
    case (m)
      MODE_X2: return 2;
      MODE_X4: return 4;
      default: return 1;
    endcase
  endfunction

  // The reserved encoding 2'b11 behaves as a single lane.
  function automatic mode_e map_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_X1 : mode_e'(m);
  endfunction

  function automatic int lane_w(input int total_w, input int lanes);
    return total_w / lanes;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed W-bit add that clamps to the two's-complement range and flags the clamp.
module mac_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] full;

  assign full  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  // The top two bits of the extended sum disagree exactly when the W-bit result wrapped.
  assign ovf_o = full[W] ^ full[W-1];
  assign sum_o = !ovf_o    ? full[W-1:0] :
                 full[W]   ? {1'b1, {(W-1){1'b0}}} :
                             {1'b0, {(W-1){1'b1}}};

endmodule

// File: rtl/mac_unit_mp.sv
// Two-stage multi-precision MAC PE: stage 1 registers lane products for every geometry,
// stage 2 does per-lane saturating accumulation; a drain port snapshots the accumulator.
module mac_unit_mp
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_acc,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] weight_in,
  input  logic [DATA_W-1:0] input_in,
  output logic [DATA_W-1:0] weight_out,
  output logic [DATA_W-1:0] input_out,
  output logic [ACC_W-1:0]  accumulator,
  output logic              valid_out,
  output logic              sat_flag,
  input  logic              drain,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              drain_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0]    weight_out_q, input_out_q;
  logic [PROD_W-1:0]    prod_d [NUM_GEOM];
  logic [PROD_W-1:0]    prod_q [NUM_GEOM];
  logic                 en_q;
  mode_e                mode_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic [ACC_W-1:0]     result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 drain_ovf_q, drain_ovf_d;

  logic [ACC_W-1:0]     sum_w [NUM_GEOM];
  logic [MAX_LANES-1:0] ovf_w [NUM_GEOM];
  logic [ACC_W-1:0]     acc_upd, acc_next;
  logic [MAX_LANES-1:0] lane_ovf;
  logic                 drain_accept;

  // Geometry g holds lanes_of(g) lanes; all three are computed every cycle.
  for (genvar g = 0; g < NUM_GEOM; g++) begin : g_geom
    localparam int L  = lanes_of(mode_e'(g));
    localparam int OW = lane_w(DATA_W, L);
    localparam int PW = 2 * OW;
    localparam int AW = lane_w(ACC_W, L);

    for (genvar i = 0; i < L; i++) begin : g_lane
      logic signed [OW-1:0] w_l, x_l;
      logic signed [PW-1:0] p_l;

      assign w_l = weight_in[i*OW +: OW];
      assign x_l = input_in[i*OW +: OW];
      assign prod_d[g][i*PW +: PW] = PW'(w_l) * PW'(x_l);
      assign p_l = prod_q[g][i*PW +: PW];

      mac_sat_add #(.W(AW)) u_sat (
        .a_i   (acc_q[i*AW +: AW]),
        .b_i   (AW'(p_l)),
        .sum_o (sum_w[g][i*AW +: AW]),
        .ovf_o (ovf_w[g][i])
      );
    end

    if (L < MAX_LANES) begin : g_pad
      assign ovf_w[g][MAX_LANES-1:L] = '0;
    end
  end

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    acc_upd  = sum_w[0];
    lane_ovf = ovf_w[0];
    case (mode_q)
      MODE_X2: begin
        acc_upd  = sum_w[1];
        lane_ovf = ovf_w[1];
      end
      MODE_X4: begin
        acc_upd  = sum_w[2];
        lane_ovf = ovf_w[2];
      end
      default: ;
    endcase

    acc_next = en_q ? acc_upd : acc_q;

    if (clear_acc) begin
      acc_d   = '0;
      sat_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      acc_d   = acc_next;
      sat_d   = sat_q | (en_q & (|lane_ovf));
      valid_d = en_q;
    end

    // Drain sees the un-cleared next value, so drain + clear_acc is read-then-clear.
    drain_accept   = drain & (~result_valid_q | result_ready);
    result_d       = result_q;
    result_valid_d = result_valid_q & ~result_ready;
    drain_ovf_d    = drain_ovf_q | (drain & ~drain_accept);
    if (drain_accept) begin
      result_d       = acc_next;
      result_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: product registers are reset too, so nothing stale can reach the accumulator after reset.
    if (!reset_n) begin
      weight_out_q   <= '0;
      input_out_q    <= '0;
      for (int g = 0; g < NUM_GEOM; g++) prod_q[g] <= '0;
      en_q           <= 1'b0;
      mode_q         <= MODE_X1;
      acc_q          <= '0;
      valid_q        <= 1'b0;
      sat_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      drain_ovf_q    <= 1'b0;
    end else begin
      weight_out_q   <= weight_in;
      input_out_q    <= input_in;
      for (int g = 0; g < NUM_GEOM; g++) prod_q[g] <= prod_d[g];
      en_q           <= enable & ~clear_acc;
      mode_q         <= map_mode(mode);
      acc_q          <= acc_d;
      valid_q        <= valid_d;
      sat_q          <= sat_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      drain_ovf_q    <= drain_ovf_d;
    end
  end

  assign weight_out   = weight_out_q;
  assign input_out    = input_out_q;
  assign accumulator  = acc_q;
  assign valid_out    = valid_q;
  assign sat_flag     = sat_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign drain_ovf    = drain_ovf_q;

endmodule
